// File: rtl/bp_cacc_vdp_mac.sv
// Streaming multiply-accumulate engine for the vector dot-product accelerator.
// Accepts a length-programmable command, consumes (a, b) operand pairs on a
// ready/valid handshake, multiplies them in a fixed-depth pipeline, sums the
// truncated products and offers the dot product on a valid/yumi interface.

module bp_cacc_vdp_mac #(
    parameter int data_width_p = 64,
    parameter int len_width_p  = 8,
    parameter int mul_stages_p = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    start_v_i,
    input  logic [len_width_p-1:0]  start_len_i,
    output logic                    start_ready_o,
    input  logic                    clear_i,
    input  logic                    elem_v_i,
    input  logic [data_width_p-1:0] elem_a_i,
    input  logic [data_width_p-1:0] elem_b_i,
    output logic                    elem_ready_o,
    output logic                    res_v_o,
    output logic [data_width_p-1:0] res_o,
    input  logic                    res_yumi_i,
    output logic                    busy_o,
    output logic [len_width_p-1:0]  elem_cnt_o
);

    typedef enum logic [1:0] {
        e_idle   = 2'd0,
        e_accum  = 2'd1,
        e_drain  = 2'd2,
        e_result = 2'd3
    } state_e;

    localparam logic [len_width_p-1:0] len_one_lp = {{(len_width_p-1){1'b0}}, 1'b1};

    state_e                    state_q, state_d;
    logic [len_width_p-1:0]    len_q, len_d;
    logic [len_width_p-1:0]    cnt_q, cnt_d;
    logic [data_width_p-1:0]   acc_q, acc_d;
    logic [mul_stages_p-1:0]   pv_q, pv_d;
    logic [data_width_p-1:0]   pp_q [mul_stages_p];

    logic start_hs_s;
    logic elem_hs_s;
    logic yumi_hs_s;
    logic last_elem_s;

    // Outputs decode directly from registered state so they carry no input paths.
    assign start_ready_o = (state_q == e_idle);
    assign elem_ready_o  = (state_q == e_accum) && (cnt_q < len_q);
    assign res_v_o       = (state_q == e_result);
    assign res_o         = acc_q;
    assign busy_o        = (state_q != e_idle);
    assign elem_cnt_o    = cnt_q;

    assign start_hs_s  = start_v_i & start_ready_o;
    assign elem_hs_s   = elem_v_i & elem_ready_o;
    assign yumi_hs_s   = res_yumi_i & res_v_o;
    assign last_elem_s = elem_hs_s && ((cnt_q + len_one_lp) == len_q);

    // Next-state, command length and accepted-count logic; clear wins over any handshake.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = e_idle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                e_idle: begin
                    if (start_hs_s) begin
                        len_d   = start_len_i;
                        cnt_d   = '0;
                        state_d = (start_len_i == '0) ? e_result : e_accum;
                    end else begin
                        state_d = e_idle;
                    end
                end
                e_accum: begin
                    if (elem_hs_s) begin
                        cnt_d = cnt_q + len_one_lp;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (last_elem_s) begin
                        state_d = e_drain;
                    end else begin
                        state_d = e_accum;
                    end
                end
                e_drain: begin
                    // Empty pipe means the last product was summed on the edge that emptied it.
                    if (pv_q == '0) begin
                        state_d = e_result;
                    end else begin
                        state_d = e_drain;
                    end
                end
                e_result: begin
                    if (yumi_hs_s) begin
                        state_d = e_idle;
                    end else begin
                        state_d = e_result;
                    end
                end
                default: begin
                    state_d = e_idle;
                end
            endcase
        end
    end

    // Pipeline valid bits shift one stage per edge; stage 0 loads on an element handshake.
    always_comb begin
        pv_d = '0;
        if (clear_i) begin
            pv_d = '0;
        end else begin
            pv_d[0] = elem_hs_s;
            for (int i = 1; i < mul_stages_p; i++) begin
                pv_d[i] = pv_q[i-1];
            end
        end
    end

    // Accumulator: cleared by clear or start, otherwise adds the product leaving the pipe.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (start_hs_s) begin
            acc_d = '0;
        end else if (pv_q[mul_stages_p-1]) begin
            acc_d = acc_q + pp_q[mul_stages_p-1];
        end else begin
            acc_d = acc_q;
        end
    end

    // Control and accumulator registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            pv_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pv_q    <= pv_d;
        end
    end

    // Product data pipeline; qualified by pv_q, so data moves every cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < mul_stages_p; i++) begin
                pp_q[i] <= '0;
            end
        end else begin
            pp_q[0] <= elem_a_i * elem_b_i;
            for (int i = 1; i < mul_stages_p; i++) begin
                pp_q[i] <= pp_q[i-1];
            end
        end
    end

    bp_cacc_vdp_mac_chk u_chk (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .res_v_i    (res_v_o),
        .res_yumi_i (res_yumi_i)
    );

endmodule

// Protocol checker: yumi may only be raised while a result is offered.
module bp_cacc_vdp_mac_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic res_v_i,
    input logic res_yumi_i
);

    a_yumi_only_with_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) res_yumi_i |-> res_v_i
    );

endmodule

// File: tb/tb_bp_cacc_vdp_mac.sv
// Self-checking bench for bp_cacc_vdp_mac: directed scenarios plus randomized
// commands, checked against a dot-product model computed with plain arithmetic.

module tb_bp_cacc_vdp_mac;

    localparam int DW = 64;
    localparam int LW = 8;
    localparam int MS = 2;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          start_v_i = 1'b0;
    logic [LW-1:0] start_len_i = '0;
    logic          start_ready_o;
    logic          clear_i = 1'b0;
    logic          elem_v_i = 1'b0;
    logic [DW-1:0] elem_a_i = '0;
    logic [DW-1:0] elem_b_i = '0;
    logic          elem_ready_o;
    logic          res_v_o;
    logic [DW-1:0] res_o;
    logic          res_yumi_i = 1'b0;
    logic          busy_o;
    logic [LW-1:0] elem_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] a_arr [256];
    logic [DW-1:0] b_arr [256];

    always #5 clk_i = ~clk_i;

    bp_cacc_vdp_mac #(.data_width_p(DW), .len_width_p(LW), .mul_stages_p(MS)) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_v_i     (start_v_i),
        .start_len_i   (start_len_i),
        .start_ready_o (start_ready_o),
        .clear_i       (clear_i),
        .elem_v_i      (elem_v_i),
        .elem_a_i      (elem_a_i),
        .elem_b_i      (elem_b_i),
        .elem_ready_o  (elem_ready_o),
        .res_v_o       (res_v_o),
        .res_o         (res_o),
        .res_yumi_i    (res_yumi_i),
        .busy_o        (busy_o),
        .elem_cnt_o    (elem_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r;
    endfunction

    // One full command: start, feed len pairs, wait for the result, hold it, consume it.
    // mode: 0 = valid every cycle, 1 = valid toggles 1,0,1,..., 2 = random gaps.
    task automatic run_cmd(input int len, input int mode, input int hold, input bit start_in_hold);
        logic [63:0] sum;
        int cnt;
        int guard;
        int k;
        bit v;
        sum = '0;
        check("idle_start_ready", start_ready_o, 1);
        check("idle_busy", busy_o, 0);
        start_v_i   = 1'b1;
        start_len_i = len[LW-1:0];
        tick();
        start_v_i = 1'b0;
        if (len == 0) begin
            elem_v_i = 1'b1;
            elem_a_i = rnd64();
            elem_b_i = rnd64();
            check("len0_res_v", res_v_o, 1);
            check("len0_res", res_o, 0);
            check("len0_elem_ready", elem_ready_o, 0);
            tick();
            check("len0_cnt", elem_cnt_o, 0);
            check("len0_res_v_hold", res_v_o, 1);
            elem_v_i = 1'b0;
        end else begin
            cnt   = 0;
            guard = 0;
            while (cnt < len && guard < 2000) begin
                check("accum_ready", elem_ready_o, 1);
                check("accum_cnt", elem_cnt_o, cnt);
                check("accum_busy", busy_o, 1);
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (guard % 2 == 0);
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                elem_v_i = v;
                elem_a_i = v ? a_arr[cnt] : rnd64();
                elem_b_i = v ? b_arr[cnt] : rnd64();
                tick();
                guard++;
                if (v) begin
                    sum = sum + a_arr[cnt] * b_arr[cnt];
                    cnt++;
                end
            end
            if (guard >= 2000) check("accum_timeout", 0, 1);
            // Keep valid asserted with junk data: it must be ignored after the last pair.
            elem_v_i = 1'b1;
            elem_a_i = rnd64();
            elem_b_i = rnd64();
            k = 1;
            while (res_v_o !== 1'b1 && k < 20) begin
                check("drain_ready", elem_ready_o, 0);
                check("drain_cnt", elem_cnt_o, len);
                tick();
                k++;
            end
            elem_v_i = 1'b0;
            check("latency", k, MS + 2);
            check("result", res_o, sum);
            check("final_cnt", elem_cnt_o, len);
        end
        for (int i = 0; i < hold; i++) begin
            check("hold_res_v", res_v_o, 1);
            check("hold_res", res_o, sum);
            check("hold_start_ready", start_ready_o, 0);
            if (start_in_hold && i == hold / 2) begin
                start_v_i   = 1'b1;
                start_len_i = 8'd3;
            end
            tick();
            start_v_i = 1'b0;
        end
        // Consume the result with a competing start in the same cycle; the start is lost.
        res_yumi_i  = 1'b1;
        start_v_i   = 1'b1;
        start_len_i = 8'd1;
        tick();
        res_yumi_i = 1'b0;
        start_v_i  = 1'b0;
        check("post_yumi_res_v", res_v_o, 0);
        check("post_yumi_start_ready", start_ready_o, 1);
        check("post_yumi_busy", busy_o, 0);
        check("post_yumi_cnt", elem_cnt_o, len);
    endtask

    initial begin
        int len;
        // Asynchronous reset: outputs must settle before any clock edge.
        #1 reset_n_i = 1'b0;
        #1;
        check("rst_start_ready", start_ready_o, 1);
        check("rst_elem_ready", elem_ready_o, 0);
        check("rst_res_v", res_v_o, 0);
        check("rst_res", res_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt", elem_cnt_o, 0);
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();

        // len=4, 1..4 dot 5..8 = 70, back-to-back.
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 64'(i + 1);
            b_arr[i] = 64'(i + 5);
        end
        run_cmd(4, 0, 1, 1'b0);
        check("dot_70_model", res_o, 70);

        // len=0 completes immediately with zero.
        run_cmd(0, 0, 2, 1'b0);

        // len=3 all-ones operands, toggling valid: sum of truncated products = 3.
        for (int i = 0; i < 3; i++) begin
            a_arr[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            b_arr[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        run_cmd(3, 1, 1, 1'b0);
        check("trunc_res", res_o, 3);

        // len=8, yumi withheld 10 cycles with a start pulse inside the window.
        for (int i = 0; i < 8; i++) begin
            a_arr[i] = rnd64();
            b_arr[i] = rnd64();
        end
        run_cmd(8, 0, 10, 1'b1);

        // len=5 aborted by clear after 2 pairs; a pair offered with clear is dropped.
        start_v_i   = 1'b1;
        start_len_i = 8'd5;
        tick();
        start_v_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            elem_v_i = 1'b1;
            elem_a_i = 64'(i + 7);
            elem_b_i = 64'(i + 9);
            tick();
        end
        check("pre_clear_cnt", elem_cnt_o, 2);
        clear_i  = 1'b1;
        elem_v_i = 1'b1;
        tick();
        clear_i  = 1'b0;
        elem_v_i = 1'b0;
        check("clear_busy", busy_o, 0);
        check("clear_cnt", elem_cnt_o, 0);
        check("clear_start_ready", start_ready_o, 1);
        for (int i = 0; i < 8; i++) begin
            check("clear_no_res", res_v_o, 0);
            tick();
        end
        a_arr[0] = 64'd3;
        b_arr[0] = 64'd3;
        run_cmd(1, 0, 0, 1'b0);
        check("after_clear_res", res_o, 9);

        // Reset asserted while draining: immediate return to reset values, no result.
        start_v_i   = 1'b1;
        start_len_i = 8'd3;
        tick();
        start_v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            elem_v_i = 1'b1;
            elem_a_i = 64'(i + 11);
            elem_b_i = 64'(i + 13);
            tick();
        end
        elem_v_i = 1'b0;
        check("drain_busy", busy_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_cnt", elem_cnt_o, 0);
        check("arst_res", res_o, 0);
        check("arst_start_ready", start_ready_o, 1);
        #1 reset_n_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arst_no_res", res_v_o, 0);
        end
        a_arr[0] = 64'd2; b_arr[0] = 64'd4;
        a_arr[1] = 64'd3; b_arr[1] = 64'd5;
        run_cmd(2, 0, 0, 1'b0);
        check("after_rst_res", res_o, 23);

        // Randomized commands.
        for (int t = 0; t < 25; t++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 60) : $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                a_arr[i] = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
                b_arr[i] = rnd64();
            end
            run_cmd(len, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
